// File: rtl/seq_game_pkg.sv
// Shared types, default parameters and helper functions for the sequence
// memory game engine.
package seq_game_pkg;

    // Game FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_GUESS = 3'd2,
        S_WON   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int          DEF_SYMBOLS      = 6;
    localparam int          DEF_MAX_ROUNDS   = 6;
    localparam int          DEF_MAX_MISTAKES = 3;
    localparam int          DEF_LFSR_W       = 16;
    localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

    // A requested round count of 0, or one beyond storage, plays the full game.
    function automatic int clamp_rounds(input int cfg, input int max_rounds);
        if (cfg <= 0 || cfg > max_rounds) begin
            return max_rounds;
        end
        return cfg;
    endfunction

    // Maximal-length tap masks for common widths; other widths fall back to
    // the top two bits, which still never lock up on a non-zero seed.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = 64'h0000_0000_0000_00B8;
            16:      taps = 64'h0000_0000_0000_B400;
            24:      taps = 64'h0000_0000_00E1_0000;
            32:      taps = 64'h0000_0000_A300_0000;
            default: taps = 64'h3 << (width - 2);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/seq_game_lfsr.sv
// Free-running Fibonacci LFSR. Shifts left every cycle; the feedback bit is
// the XOR of the tapped bits. Only the low OUT_W bits leave the block.
module seq_game_lfsr
    import seq_game_pkg::*;
#(
    parameter int               WIDTH = DEF_LFSR_W,
    parameter int               OUT_W = 3,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_LFSR_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [OUT_W-1:0] value
);

    logic [WIDTH-1:0] lfsr_q;
    logic             feedback;

    assign feedback = ^(lfsr_q & TAPS);
    assign value    = lfsr_q[OUT_W-1:0];

    // Advance the shift register on every clock, whatever the game is doing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/seq_game_core.sv
// Sequence-memory game engine: draws a new distinct symbol each round, checks
// the player's replay of the whole sequence, and reports round wins, wrong
// guesses, game won and game over. All outputs are registered except the
// sequence read port.
//
// Handshake: start and guess_valid are single-cycle strobes sampled on the
// rising clock edge; there is no ready, a strobe is either acted on in that
// cycle or ignored (guess_valid outside GUESS). start beats guess_valid.
module seq_game_core
    import seq_game_pkg::*;
#(
    parameter int              SYMBOLS      = DEF_SYMBOLS,
    parameter int              MAX_ROUNDS   = DEF_MAX_ROUNDS,
    parameter int              MAX_MISTAKES = DEF_MAX_MISTAKES,
    parameter int              LFSR_W       = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(DEF_LFSR_SEED),
    localparam int             SYM_W        = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1,
    localparam int             RND_W        = $clog2(MAX_ROUNDS + 1),
    localparam int             MIS_W        = (MAX_MISTAKES > 0) ? $clog2(MAX_MISTAKES + 1) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [RND_W-1:0] rounds_cfg,
    input  logic [SYM_W-1:0] guess,
    input  logic             guess_valid,
    input  logic [RND_W-1:0] seq_rd_idx,
    output logic [SYM_W-1:0] seq_rd_data,
    output logic [RND_W-1:0] round,
    output logic             win_pulse,
    output logic             lose_pulse,
    output logic             game_won,
    output logic             game_over,
    output logic             busy,
    output logic [MIS_W-1:0] mistakes,
    output state_t           state
);

    // Mistake counter ceiling: the limit itself, or all-ones when unlimited
    localparam logic [MIS_W-1:0] MIS_MAX = (MAX_MISTAKES == 0) ? {MIS_W{1'b1}}
                                                               : MIS_W'(MAX_MISTAKES);

    logic [SYM_W-1:0] seq [MAX_ROUNDS];
    logic [RND_W-1:0] idx;
    logic [RND_W-1:0] cfg;
    logic [RND_W-1:0] last_idx;
    logic [SYM_W-1:0] cand;
    logic [SYM_W-1:0] exp_sym;
    logic             dup;
    logic             cand_ok;
    logic             guess_hit;
    logic             limit_hit;

    seq_game_lfsr #(
        .WIDTH (LFSR_W),
        .OUT_W (SYM_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_W'(lfsr_taps(LFSR_W)))
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .value  (cand)
    );

    assign last_idx = round - RND_W'(1);

    // Candidate is usable if in the alphabet and not already in this game's sequence
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            if ((RND_W'(i) < last_idx) && (seq[i] == cand)) begin
                dup = 1'b1;
            end
        end
        cand_ok = (int'(cand) < SYMBOLS) && !dup;
    end

    // Symbol the player is expected to enter next
    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            if (RND_W'(i) == idx) begin
                exp_sym = seq[i];
            end
        end
        guess_hit = (int'(guess) < SYMBOLS) && (guess == exp_sym);
        limit_hit = (MAX_MISTAKES != 0) && ((mistakes + MIS_W'(1)) == MIS_MAX);
    end

    // Display read port: only entries of rounds already reached are visible
    always_comb begin
        seq_rd_data = '0;
        for (int i = 0; i < MAX_ROUNDS; i++) begin
            if ((RND_W'(i) == seq_rd_idx) && (RND_W'(i) < round)) begin
                seq_rd_data = seq[i];
            end
        end
    end

    // Game FSM with sequence storage and registered status outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            round      <= '0;
            idx        <= '0;
            cfg        <= '0;
            mistakes   <= '0;
            win_pulse  <= 1'b0;
            lose_pulse <= 1'b0;
            game_won   <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < MAX_ROUNDS; i++) begin
                seq[i] <= '0;
            end
        end else begin
            win_pulse  <= 1'b0;
            lose_pulse <= 1'b0;
            if (start) begin
                state     <= S_ADD;
                round     <= RND_W'(1);
                idx       <= '0;
                cfg       <= RND_W'(clamp_rounds(int'(rounds_cfg), MAX_ROUNDS));
                mistakes  <= '0;
                game_won  <= 1'b0;
                game_over <= 1'b0;
                busy      <= 1'b1;
                for (int i = 0; i < MAX_ROUNDS; i++) begin
                    seq[i] <= '0;
                end
            end else begin
                case (state)
                    S_ADD: begin
                        if (cand_ok) begin
                            for (int i = 0; i < MAX_ROUNDS; i++) begin
                                if (RND_W'(i) == last_idx) begin
                                    seq[i] <= cand;
                                end
                            end
                            idx   <= '0;
                            state <= S_GUESS;
                        end
                    end
                    S_GUESS: begin
                        if (guess_valid) begin
                            if (guess_hit) begin
                                if (idx != last_idx) begin
                                    idx <= idx + RND_W'(1);
                                end else begin
                                    win_pulse <= 1'b1;
                                    idx       <= '0;
                                    if (round == cfg) begin
                                        game_won <= 1'b1;
                                        busy     <= 1'b0;
                                        state    <= S_WON;
                                    end else begin
                                        round <= round + RND_W'(1);
                                        state <= S_ADD;
                                    end
                                end
                            end else begin
                                lose_pulse <= 1'b1;
                                idx        <= '0;
                                if (mistakes != MIS_MAX) begin
                                    mistakes <= mistakes + MIS_W'(1);
                                end
                                if (limit_hit) begin
                                    game_over <= 1'b1;
                                    busy      <= 1'b0;
                                    state     <= S_OVER;
                                end
                            end
                        end
                    end
                    default: begin
                        // IDLE, WON and OVER wait for start
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_game_core.sv
// Directed bench for seq_game_core: vector table for full games plus
// hand-written restart and reset sequences.
module tb_seq_game_core;
    import seq_game_pkg::*;

    localparam int W = 3;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [2:0]   rounds_cfg;
    logic [W-1:0] guess;
    logic         guess_valid;
    logic [2:0]   seq_rd_idx;
    logic [W-1:0] seq_rd_data;
    logic [2:0]   round;
    logic         win_pulse;
    logic         lose_pulse;
    logic         game_won;
    logic         game_over;
    logic         busy;
    logic [1:0]   mistakes;
    state_t       state;

    int tests  = 0;
    int failed = 0;
    int exp_idx = 0;
    int wins = 0;
    logic [W-1:0] exp_q[$];

    // gmode: 0 = correct symbol, 1 = wrong in-range symbol, 2 = literal glit
    typedef struct {
        logic       st;
        logic [2:0] rcfg;
        logic       gv;
        int         gmode;
        logic [2:0] glit;
        logic [2:0] e_round;
        logic       e_win;
        logic       e_lose;
        logic       e_won;
        logic       e_over;
        logic       e_busy;
        logic [1:0] e_mis;
        state_t     e_state;
    } vec_t;

    vec_t vecs[19];

    seq_game_core dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .rounds_cfg  (rounds_cfg),
        .guess       (guess),
        .guess_valid (guess_valid),
        .seq_rd_idx  (seq_rd_idx),
        .seq_rd_data (seq_rd_data),
        .round       (round),
        .win_pulse   (win_pulse),
        .lose_pulse  (lose_pulse),
        .game_won    (game_won),
        .game_over   (game_over),
        .busy        (busy),
        .mistakes    (mistakes),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic [2:0] rcfg, input logic gv,
                                input int gmode, input logic [2:0] glit,
                                input logic [2:0] er, input logic ew, input logic el,
                                input logic ewon, input logic eov, input logic eb,
                                input logic [1:0] em, input state_t es);
        vec_t v;
        v.st = st; v.rcfg = rcfg; v.gv = gv; v.gmode = gmode; v.glit = glit;
        v.e_round = er; v.e_win = ew; v.e_lose = el; v.e_won = ewon;
        v.e_over = eov; v.e_busy = eb; v.e_mis = em; v.e_state = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {19'd0, round, win_pulse, lose_pulse, game_won, game_over, busy, mistakes, state};
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {19'd0, v.e_round, v.e_win, v.e_lose, v.e_won, v.e_over, v.e_busy, v.e_mis, v.e_state};
    endfunction

    // Wait out symbol drawing, then record and vet the newly added symbol
    task automatic settle();
        int n;
        logic [W-1:0] sym;
        logic dup;
        n = 0;
        while (state == S_ADD && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (state == S_ADD) begin
            check("add_timeout", 32'(n), 32'd0);
        end
        if (state == S_GUESS && exp_q.size() < int'(round)) begin
            seq_rd_idx = 3'(exp_q.size());
            #1;
            sym = seq_rd_data;
            check("sym_range", 32'(int'(sym) < 6), 32'd1);
            dup = 1'b0;
            foreach (exp_q[k]) if (exp_q[k] == sym) dup = 1'b1;
            check("sym_distinct", 32'(dup), 32'd0);
            exp_q.push_back(sym);
            seq_rd_idx = 3'(exp_q.size());
            #1;
            check("rd_beyond_round", 32'(seq_rd_data), 32'd0);
        end
    endtask

    // driver: apply one vector, compare one cycle later, then settle
    task automatic apply_vec(input vec_t v, input int id);
        int g;
        @(negedge clk);
        start      = v.st;
        rounds_cfg = v.rcfg;
        if (v.gv) begin
            guess_valid = 1'b1;
            if (v.gmode != 2 && exp_idx >= exp_q.size()) begin
                check($sformatf("vec%0d_queue", id), 32'(exp_q.size()), 32'(exp_idx + 1));
                guess = v.glit;
            end else if (v.gmode == 0) begin
                guess = exp_q[exp_idx];
            end else if (v.gmode == 1) begin
                g = (int'(exp_q[exp_idx]) + 1) % 6;
                guess = W'(g);
            end else begin
                guess = v.glit;
            end
        end
        @(posedge clk); #1;
        start       = 1'b0;
        guess_valid = 1'b0;
        check($sformatf("vec%0d", id), pack_out(), pack_exp(v));
        if (win_pulse) wins++;
        if (v.st) begin
            exp_q.delete();
            seq_rd_idx = 3'd0;
            #1;
            check($sformatf("vec%0d_seq_cleared", id), 32'(seq_rd_data), 32'd0);
        end
        if (v.st || v.e_win || v.e_lose) exp_idx = 0;
        else if (v.gv) exp_idx++;
        @(posedge clk); #1;
        check($sformatf("vec%0d_pulse_width", id), {30'd0, win_pulse, lose_pulse}, 32'd0);
        settle();
    endtask

    initial begin
        vec_t v;
        resetn      = 1'b0;
        start       = 1'b0;
        rounds_cfg  = 3'd0;
        guess       = '0;
        guess_valid = 1'b0;
        seq_rd_idx  = 3'd0;

        // game A: 4 rounds, one miss in round 2, then a guess while WON
        vecs[0]  = mk(1, 4, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, S_ADD);
        vecs[1]  = mk(0, 0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, S_ADD);
        vecs[2]  = mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 0, S_GUESS);
        vecs[3]  = mk(0, 0, 1, 1, 0, 2, 0, 1, 0, 0, 1, 1, S_GUESS);
        vecs[4]  = mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1, S_GUESS);
        vecs[5]  = mk(0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 1, S_ADD);
        vecs[6]  = mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1, 1, S_GUESS);
        vecs[7]  = mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1, 1, S_GUESS);
        vecs[8]  = mk(0, 0, 1, 0, 0, 4, 1, 0, 0, 0, 1, 1, S_ADD);
        vecs[9]  = mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 1, 1, S_GUESS);
        vecs[10] = mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 1, 1, S_GUESS);
        vecs[11] = mk(0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 1, 1, S_GUESS);
        vecs[12] = mk(0, 0, 1, 0, 0, 4, 1, 0, 1, 0, 0, 1, S_WON);
        vecs[13] = mk(0, 0, 1, 2, 0, 4, 0, 0, 1, 0, 0, 1, S_WON);
        // game B: rounds_cfg 0, three misses (one out of range) then ignored guess
        vecs[14] = mk(1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, S_ADD);
        vecs[15] = mk(0, 0, 1, 2, 7, 1, 0, 1, 0, 0, 1, 1, S_GUESS);
        vecs[16] = mk(0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 1, 2, S_GUESS);
        vecs[17] = mk(0, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 3, S_OVER);
        vecs[18] = mk(0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 0, 3, S_OVER);

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("idle_outputs", pack_out(), {19'd0, 3'd0, 5'd0, 2'd0, S_IDLE});
        check("idle_rd_data", 32'(seq_rd_data), 32'd0);
        check("lfsr_nonzero", 32'(dut.u_lfsr.lfsr_q != '0), 32'd1);

        for (int i = 0; i < 19; i++) begin
            apply_vec(vecs[i], i);
        end

        // game C: rounds_cfg 7 clamps to six rounds, all played correctly
        wins = 0;
        apply_vec(mk(1, 7, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, S_ADD), 100);
        for (int r = 1; r <= 6; r++) begin
            for (int i = 0; i < r; i++) begin
                v = mk(0, 0, 1, 0, 0, 3'(r), 0, 0, 0, 0, 1, 0, S_GUESS);
                if (i == r - 1) begin
                    v.e_win = 1'b1;
                    if (r == 6) begin
                        v.e_won = 1'b1; v.e_busy = 1'b0; v.e_state = S_WON;
                    end else begin
                        v.e_round = 3'(r + 1); v.e_state = S_ADD;
                    end
                end
                apply_vec(v, 100 + r * 10 + i);
            end
        end
        check("six_round_wins", 32'(wins), 32'd6);

        // game D: start coincident with a wrong guess mid-game restarts cleanly
        apply_vec(mk(1, 3, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, S_ADD), 200);
        apply_vec(mk(0, 0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, S_ADD), 201);
        apply_vec(mk(0, 0, 1, 1, 0, 2, 0, 1, 0, 0, 1, 1, S_GUESS), 202);
        apply_vec(mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1, S_GUESS), 203);
        apply_vec(mk(1, 3, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, S_ADD), 204);
        apply_vec(mk(0, 0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, S_ADD), 205);

        // asynchronous reset in the middle of a game
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("async_reset", pack_out(), {19'd0, 3'd0, 5'd0, 2'd0, S_IDLE});
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", pack_out(), {19'd0, 3'd0, 5'd0, 2'd0, S_IDLE});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_game_core.md
Name: seq_game_core

Overview:
- Parametrised sequence-memory game engine for the memory game.
- Generalises the existing symbol-memory, round-FSM and win/lose logic into one synchronous block.
- Configurable symbol alphabet, maximum rounds and mistake limit; runtime round count.
- Feeds the hex/VGA display path and the scoreboard via pulses, status flags and a sequence read port.

Parameters:
- SYMBOLS, 6: alphabet size; symbols are 0..SYMBOLS-1; must be >= MAX_ROUNDS.
- MAX_ROUNDS, 6: sequence storage depth and maximum rounds per game.
- MAX_MISTAKES, 3: wrong guesses allowed before game over; 0 = unlimited.
- LFSR_W, 16: width of the internal Fibonacci LFSR.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.
- Derived, not overridable: SYM_W = $clog2(SYMBOLS); RND_W = $clog2(MAX_ROUNDS+1); MIS_W = $clog2(MAX_MISTAKES+1), minimum 1.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin a new game, or abort and restart a running one.
- rounds_cfg  in  RND_W  rounds for this game; sampled on start; 0 or >MAX_ROUNDS means MAX_ROUNDS.
- guess  in  SYM_W  player symbol.
- guess_valid  in  1  one-cycle pulse qualifying guess.
- seq_rd_idx  in  RND_W  read address into stored sequence.
- seq_rd_data  out  SYM_W  combinational read of seq[seq_rd_idx]; 0 if idx >= round.
- round  out  RND_W  current round, 1-based; 0 when idle.
- win_pulse  out  1  one cycle when a round is completed.
- lose_pulse  out  1  one cycle on a wrong guess.
- game_won  out  1  level; all configured rounds completed.
- game_over  out  1  level; mistake limit reached.
- busy  out  1  high in ADD and GUESS states.
- mistakes  out  MIS_W  wrong guesses in the current game.

Behaviour:
- Reset: state IDLE; round=0; all seq entries 0; mistakes=0; win_pulse, lose_pulse, game_won, game_over, busy = 0; LFSR=LFSR_SEED.
- LFSR: advances every cycle in every state, including IDLE, so the drawn sequence depends on when start arrives.
- States: IDLE, ADD, GUESS, WON, OVER.
- Any state, start=1, next cycle:
  - clear seq, idx, mistakes, game_won, game_over;
  - latch rounds_cfg into cfg (clamped as above);
  - round=1; go to ADD.
  - start has priority over a coincident guess_valid.
- ADD:
  - Each cycle the candidate is lfsr[SYM_W-1:0].
  - Accept if candidate < SYMBOLS and it differs from seq[0..round-2].
  - On accept: write seq[round-1]=candidate, idx=0, go to GUESS.
  - Otherwise stay in ADD.
  - guess_valid is ignored in ADD.
- GUESS, on guess_valid:
  - Correct (guess==seq[idx]) and idx < round-1: idx++.
  - Correct and idx==round-1: win_pulse next cycle.
    - If round==cfg: game_won=1, go to WON; round holds its value.
    - Else round++, go to ADD.
  - Wrong (includes guess >= SYMBOLS): lose_pulse next cycle, idx=0, mistakes++, round is replayed.
    - If MAX_MISTAKES != 0 and mistakes+1 == MAX_MISTAKES: game_over=1, go to OVER.
- WON and OVER: terminal; hold all outputs; guess_valid is ignored; only start or reset leaves.
- All outputs are registered except seq_rd_data.
- Pulse latency: exactly 1 cycle after the guess_valid cycle.
- Reset mid-game: immediate return to reset values, with no pulse emitted.
- mistakes saturates at MAX_MISTAKES; when MAX_MISTAKES=0 it saturates at all-ones.

Decomposition:
- Package seq_game_pkg holds:
  - the state enum (IDLE, ADD, GUESS, WON, OVER);
  - default parameter constants;
  - function clamp_rounds().
- Sub-module seq_game_lfsr: parametrised width, seed and taps; free-running, async active-low reset.
- The sequence RAM and FSM stay in seq_game_core.

Test Plan:
- Reset then idle 100 cycles -> round=0, busy=0, all flags 0; LFSR state != 0.
- start with rounds_cfg=4; answer each round correctly, reading symbols via seq_rd_idx -> 4 win_pulses; round steps 1,2,3,4; game_won=1 in WON; 4 stored symbols all distinct and <6.
- Round 2, second guess wrong -> lose_pulse 1 cycle later, mistakes=1, round stays 2, idx restarts; correct replay -> win_pulse, round=3.
- 3 wrong guesses in round 1 (MAX_MISTAKES=3) -> game_over=1, state OVER; a 4th guess_valid gives no pulse and mistakes stays 3.
- start and guess_valid in the same cycle mid-game -> restart, no lose_pulse, mistakes=0, round=1.
- rounds_cfg=0, and separately rounds_cfg=7 -> game runs 6 rounds; guess=7 (out of range) counts as wrong.
